// File: rtl/r2sdf_bfly_stage_32b.sv
// Radix-2 single-delay-feedback butterfly stage, packed {re,im} 16-bit samples.
// Ports:
//   clk, rst_n (async low)
//   in_valid, in_data[31:0]
//   out_valid, out_data[31:0], out_twiddle_sel, out_sync
// Optional macro BFLY_SCALE_EN: results are halved (>>>1) instead of wrapped.
module r2sdf_bfly_stage_32b #(
  parameter int DELAY = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_twiddle_sel,
  output logic        out_sync
);

  localparam int AW = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_primed;
  logic [31:0]      r_dly [DELAY];

  logic             w_phase;
  logic [AW-1:0]    w_idx;
  logic [31:0]      w_d;
  logic [16:0]      w_sum_re;
  logic [16:0]      w_sum_im;
  logic [16:0]      w_dif_re;
  logic [16:0]      w_dif_im;
  logic [31:0]      w_sum;
  logic [31:0]      w_dif;

  function automatic logic [15:0] reduce(input logic [16:0] v);
`ifdef BFLY_SCALE_EN
    return v[16:1];
`else
    return v[15:0];
`endif
  endfunction

  // Both phases address the same slot: entry i is filled in
  // phase 0 and revisited DELAY samples later in phase 1.
  assign w_phase = r_cnt[CNT_W-1];
  assign w_idx   = AW'(r_cnt & CNT_W'(DELAY - 1));
  assign w_d     = r_dly[w_idx];

  assign w_sum_re = {w_d[31], w_d[31:16]}
                  + {in_data[31], in_data[31:16]};
  assign w_sum_im = {w_d[15], w_d[15:0]}
                  + {in_data[15], in_data[15:0]};
  assign w_dif_re = {w_d[31], w_d[31:16]}
                  - {in_data[31], in_data[31:16]};
  assign w_dif_im = {w_d[15], w_d[15:0]}
                  - {in_data[15], in_data[15:0]};

  assign w_sum = {reduce(w_sum_re), reduce(w_sum_im)};
  assign w_dif = {reduce(w_dif_re), reduce(w_dif_im)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt           <= '0;
      r_primed        <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_twiddle_sel <= 1'b0;
      out_sync        <= 1'b0;
      for (int i = 0; i < DELAY; i++) begin
        r_dly[i] <= '0;
      end
    end else if (in_valid) begin
      r_cnt     <= r_cnt + 1'b1;
      out_valid <= w_phase | r_primed;
      out_sync  <= (r_cnt == CNT_W'(DELAY));
      if (w_phase) begin
        r_primed        <= 1'b1;
        r_dly[w_idx]    <= w_dif;
        out_data        <= w_sum;
        out_twiddle_sel <= 1'b0;
      end else begin
        r_dly[w_idx]    <= in_data;
        out_data        <= w_d;
        out_twiddle_sel <= 1'b1;
      end
    end else begin
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_r2sdf_bfly_stage_32b.sv
// Scoreboard bench for r2sdf_bfly_stage_32b (DELAY=2 and DELAY=32).
// Expected values follow BFLY_SCALE_EN when defined.
module tb_r2sdf_bfly_stage_32b;

`ifdef BFLY_SCALE_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic        t;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_iv = 1'b0;
  logic [31:0] a_id = '0;
  logic        a_ov;
  logic [31:0] a_od;
  logic        a_ts;
  logic        a_sy;

  logic        b_iv = 1'b0;
  logic [31:0] b_id = '0;
  logic        b_ov;
  logic [31:0] b_od;
  logic        b_ts;
  logic        b_sy;

  int errors = 0;
  int checks = 0;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  r2sdf_bfly_stage_32b #(.DELAY(2), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_iv), .in_data(a_id),
    .out_valid(a_ov), .out_data(a_od),
    .out_twiddle_sel(a_ts), .out_sync(a_sy)
  );

  r2sdf_bfly_stage_32b #(.DELAY(32), .CNT_W(6)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_iv), .in_data(b_id),
    .out_valid(b_ov), .out_data(b_od),
    .out_twiddle_sel(b_ts), .out_sync(b_sy)
  );

  // stimulus table for the DELAY=2 instance:
  // input re, expect valid, unscaled, scaled, twiddle, sync
  int t_in[35] = '{1,2,3,4, 5,6,7,8, 0,0,3,0,
                   32767,0,1,0, 0,0,0,0,
                   1,2,3,4, 5,6,7,8, 9,9,9, 1,2,3,4};
  int t_ev[35] = '{0,0,1,1, 1,1,1,1, 1,1,1,1,
                   1,1,1,1, 1,1,1,1,
                   1,1,1,1, 1,1,1,1, 1,1,1, 0,0,1,1};
  int t_u[35]  = '{0,0,4,6, -2,-2,12,14, -2,-2,3,0,
                   -3,0,32768,0, 32766,0,0,0,
                   0,0,4,6, -2,-2,12,14, -2,-2,18, 0,0,4,6};
  int t_s[35]  = '{0,0,2,3, -1,-1,6,7, -1,-1,1,0,
                   -2,0,16384,0, 16383,0,0,0,
                   0,0,2,3, -1,-1,6,7, -1,-1,9, 0,0,2,3};
  int t_t[35]  = '{0,0,0,0, 1,1,0,0, 1,1,0,0,
                   1,1,0,0, 1,1,0,0,
                   1,1,0,0, 1,1,0,0, 1,1,0, 0,0,0,0};
  int t_y[35]  = '{0,0,1,0, 0,0,1,0, 0,0,1,0,
                   0,0,1,0, 0,0,1,0,
                   0,0,1,0, 0,0,1,0, 0,0,1, 0,0,1,0};

  logic [31:0] xin [256];

  function automatic logic [15:0] pick(input int u, input int s);
    return SC ? 16'(s) : 16'(u);
  endfunction

  function automatic logic [15:0] red(input int v);
    return SC ? 16'(v >>> 1) : 16'(v);
  endfunction

  function automatic int sre(input logic [31:0] x);
    return int'($signed(x[31:16]));
  endfunction

  function automatic int sim(input logic [31:0] x);
    return int'($signed(x[15:0]));
  endfunction

  task automatic drv_a(input logic v, input int re);
    @(posedge clk);
    #1;
    a_iv = v;
    a_id = {16'(re), 16'h0000};
  endtask

  task automatic drv_b(input logic v, input logic [31:0] x);
    @(posedge clk);
    #1;
    b_iv = v;
    b_id = x;
  endtask

  task automatic step_a(input int k, input int gap);
    exp_t e;
    drv_a(1'b1, t_in[k]);
    if (t_ev[k] != 0) begin
      e.d = {pick(t_u[k], t_s[k]), 16'h0000};
      e.t = t_t[k][0];
      e.s = t_y[k][0];
      qa.push_back(e);
    end
    for (int g = 0; g < gap; g++) drv_a(1'b0, 0);
  endtask

  task automatic chk(input string nm, input logic [33:0] act,
                     input logic [33:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, {a_ov, a_od, a_ts}, 34'h0);
    chk({nm, "_a_sync"}, {33'h0, a_sy}, 34'h0);
    chk({nm, "_b"}, {b_ov, b_od, b_ts}, 34'h0);
    chk({nm, "_b_sync"}, {33'h0, b_sy}, 34'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a_ov) begin
      if (qa.size() == 0) begin
        chk("a_extra", {a_od, a_ts, a_sy}, 34'h3_ffff_ffff);
      end else begin
        e = qa.pop_front();
        chk("a_out", {a_od, a_ts, a_sy}, {e.d, e.t, e.s});
      end
    end
    if (rst_n && b_ov) begin
      if (qb.size() == 0) begin
        chk("b_extra", {b_od, b_ts, b_sy}, 34'h3_ffff_ffff);
      end else begin
        e = qb.pop_front();
        chk("b_out", {b_od, b_ts, b_sy}, {e.d, e.t, e.s});
      end
    end
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 8) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_drain"}, 34'(qa.size() + qb.size()), 34'h0);
  endtask

  initial begin
    exp_t e;
    int f;
    int i;
    #3;
    chk_zero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) step_a(k, 0);
    for (int k = 20; k < 28; k++) step_a(k, 3);
    for (int k = 28; k < 31; k++) step_a(k, 0);
    drv_a(1'b0, 0);
    drv_a(1'b0, 0);
    drain("a_main");
    chk("hold", {a_ov, a_od, a_ts},
        {1'b0, pick(18, 9), 16'h0000, 1'b0});

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 31; k < 35; k++) step_a(k, 0);
    drv_a(1'b0, 0);
    drain("a_restart");

    for (int n = 0; n < 256; n++) begin
      xin[n] = (n < 192) ? {16'(-n), 16'(n)} : 32'h0;
    end
    for (int n = 0; n < 224; n++) begin
      f = n / 64;
      i = n % 64;
      drv_b(1'b1, xin[n]);
      if (i < 32 && f > 0) begin
        e.d = {red(sre(xin[(f-1)*64+i]) - sre(xin[(f-1)*64+i+32])),
               red(sim(xin[(f-1)*64+i]) - sim(xin[(f-1)*64+i+32]))};
        e.t = 1'b1;
        e.s = 1'b0;
        qb.push_back(e);
      end else if (i >= 32) begin
        e.d = {red(sre(xin[n-32]) + sre(xin[n])),
               red(sim(xin[n-32]) + sim(xin[n]))};
        e.t = 1'b0;
        e.s = (i == 32);
        qb.push_back(e);
      end
    end
    drv_b(1'b0, 32'h0);
    drain("b_ramp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/r2sdf_bfly_stage_32b.md
Name: r2sdf_bfly_stage_32b

Overview:
Radix-2 single-delay-feedback (R2SDF) butterfly stage for the 64-point FFT pipeline. Consumes one packed complex sample per accepted cycle and produces butterfly sums and differences in streaming order. Sits directly upstream of the twiddle multipliers. out_twiddle_sel marks the difference samples that the downstream twiddle stage (e.g. the W_N^{N/4}, ×(-j) multiplier) must rotate. Samples are 32-bit packed {real[31:16], imag[15:0]}, 16-bit two's complement per component.

Parameters:
DELAY, 32, feedback delay-line depth in samples (N/2^s for stage s); power of two, 1..32
CNT_W, 6, width of the frame-position counter; must equal log2(2*DELAY)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_data valid this cycle; no backpressure
in_data  input  32  input sample {re, im}
out_valid  output  1  out_data valid
out_data  output  32  butterfly output {re, im}
out_twiddle_sel  output  1  1 = difference sample, twiddle required downstream
out_sync  output  1  1 on the first valid output of each frame (first sum)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: cnt=0, primed=0, all delay-line entries=0, out_valid=0, out_data=0, out_twiddle_sel=0, out_sync=0. Reset mid-frame discards the partial frame; the first frame after reset is handled as a fresh start.
- Stall: in_valid=0 freezes cnt, delay line and primed. out_valid=0 on the following cycle; out_data holds its last value.
- Frame: 2*DELAY accepted samples. cnt increments per accepted sample and wraps from 2*DELAY-1 to 0. phase = cnt[CNT_W-1].
- Let d = delay-line head (oldest entry) and x = in_data.
- Phase 0 (cnt < DELAY): write x into the delay line and output d. d is the previous frame's difference; out_twiddle_sel=1.
- Phase 1 (cnt >= DELAY): output d+x with out_twiddle_sel=0, and write d-x into the delay line.
- Arithmetic is per component, re and im independent. Full 17-bit signed sum/difference, then reduced to 16 bits as set by BFLY_SCALE_EN.
- Latency: all outputs registered; result appears exactly 1 cycle after the accepting clock edge.
- Priming:
  - primed is set on the first accepted sample with phase=1 and stays set until reset.
  - out_valid = registered (in_valid && (phase==1 || primed)).
  - Phase-0 outputs of the first frame after reset, which are stale zeros, are never flagged valid.
- out_sync: registered, 1 when the accepted sample has cnt==DELAY.
- Delay line: circular buffer of DELAY entries with read and write at the same index. One read and one write per accepted cycle. Read-before-write: d is the old content.

Optional Feature:
Macro BFLY_SCALE_EN.
- Defined: each 17-bit result is arithmetically shifted right by 1 and truncated to 16 bits (divide-by-2 per stage, cannot overflow).
- Undefined: the low 16 bits of the 17-bit result are taken (two's-complement wrap on overflow, no saturation). Callers scale inputs externally.

Test Plan:
- Reset values: DELAY=2; assert rst_n=0 mid-stream -> all outputs 0 asynchronously. After release, the first two accepted samples give out_valid=0.
- Basic butterfly, scale off: DELAY=2, inputs re=1,2,3,4 then 5,6,7,8 (im=0), continuous in_valid.
  - Outputs re=4,6 (twiddle_sel=0, sync on the 4).
  - Then -2,-2 (twiddle_sel=1).
  - Then 12,14.
  - Each output 1 cycle after its input.
- Scaling on (BFLY_SCALE_EN): same stimulus -> re=2,3,-1,-1,6,7.
  - -3>>>1 = -2 case: inputs 0,0,3,0 -> diff out re=-2.
- Stall: DELAY=2 basic stimulus with in_valid=0 for 3 cycles after each sample -> same output sequence, out_valid gaps of 3 cycles, cnt/wrap unchanged.
- Overflow wrap, scale off: inputs re=0x7FFF,x,0x0001,x -> sum re=0x8000 (wrapped); diff 0x7FFE appears next frame.
- Imag path and sync: DELAY=32, 3 frames of ramp im=n, re=-n.
  - Sums/diffs match the reference model.
  - out_sync pulses exactly once per 64 valid outputs.
  - twiddle_sel toggles every 32 valid outputs.
